// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
//
// Frame: 1 start bit (0), DATA_WIDTH data bits LSB first, 1 odd-parity bit,
// 1 stop bit (1). Runs on one clock at OVERSAMPLE x baud and samples each
// bit at its midpoint.
//
// Ports:
//   uart_clk   - clock, OVERSAMPLE x baud
//   rst_n      - asynchronous active-low reset
//   rx_in      - serial line (asynchronous, idles high)
//   rx_data    - last received word, held until the next rx_valid
//   rx_valid   - one-cycle pulse when rx_data/parity_err/frame_err update
//   parity_err - last frame failed the odd-parity check
//   frame_err  - last frame's stop bit was sampled low
//   rx_busy    - receiver is inside a frame (FSM not idle)
module uart_rx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                  uart_clk,
    input  logic                  rst_n,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  rx_busy
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] OS_LAST   = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    logic s1_q, s2_q, s2_prev_q;

    state_t                  state_q,     state_d;
    logic [CW-1:0]           os_cnt_q,    os_cnt_d;
    logic [BW-1:0]           bit_idx_q,   bit_idx_d;
    logic [DATA_WIDTH-1:0]   shift_q,     shift_d;
    logic                    perr_nxt_q,  perr_nxt_d;
    logic                    ferr_nxt_q,  ferr_nxt_d;
    logic                    stop_seen_q, stop_seen_d;
    logic [DATA_WIDTH-1:0]   data_q,      data_d;
    logic                    perr_q,      perr_d;
    logic                    ferr_q,      ferr_d;
    logic                    valid_q,     valid_d;

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            s2_prev_q <= 1'b1;
        end else begin
            s1_q      <= rx_in;
            s2_q      <= s1_q;
            s2_prev_q <= s2_q;
        end
    end

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            os_cnt_q    <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            perr_nxt_q  <= 1'b0;
            ferr_nxt_q  <= 1'b0;
            stop_seen_q <= 1'b0;
            data_q      <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            os_cnt_q    <= os_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            perr_nxt_q  <= perr_nxt_d;
            ferr_nxt_q  <= ferr_nxt_d;
            stop_seen_q <= stop_seen_d;
            data_q      <= data_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            valid_q     <= valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        os_cnt_d    = os_cnt_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        perr_nxt_d  = perr_nxt_q;
        ferr_nxt_d  = ferr_nxt_q;
        stop_seen_d = 1'b0;
        data_d      = data_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        valid_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                os_cnt_d = '0;
                // Only a high->low transition arms the receiver, so a line
                // stuck low after a framing error never starts a frame.
                if (s2_prev_q && !s2_q) begin
                    state_d = START;
                end
            end

            START: begin
                if (os_cnt_q == HALF_LAST) begin
                    os_cnt_d  = '0;
                    bit_idx_d = '0;
                    state_d   = s2_q ? IDLE : DATA;
                end
            end

            DATA: begin
                if (os_cnt_q == OS_LAST) begin
                    os_cnt_d = '0;
                    shift_d  = {s2_q, shift_q[DATA_WIDTH-1:1]};
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end

            PARITY: begin
                if (os_cnt_q == OS_LAST) begin
                    os_cnt_d   = '0;
                    perr_nxt_d = (s2_q != ~^shift_q);
                    state_d    = STOP;
                end
            end

            STOP: begin
                // The stop bit is sampled mid-bit; the word is published one
                // cycle later, which also drops back to IDLE half a bit early
                // so a directly following start edge is not missed.
                if (stop_seen_q) begin
                    os_cnt_d = '0;
                    state_d  = IDLE;
                    valid_d  = 1'b1;
                    data_d   = shift_q;
                    perr_d   = perr_nxt_q;
                    ferr_d   = ferr_nxt_q;
                end else if (os_cnt_q == OS_LAST) begin
                    ferr_nxt_d  = !s2_q;
                    stop_seen_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign rx_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed testbench for uart_rx with a frame-level reference
// model. Each frame the bench sends queues the edge at which its word must
// appear and the flags it must carry; a negedge compare process checks all
// outputs every cycle against that model.
module tb_uart_rx;

    localparam int DW    = 8;
    localparam int OS    = 16;
    localparam int FRAME = (DW + 3) * OS;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_in = 1'b1;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          parity_err;
    logic          frame_err;
    logic          rx_busy;

    uart_rx #(
        .DATA_WIDTH(DW),
        .OVERSAMPLE(OS)
    ) dut (
        .uart_clk  (clk),
        .rst_n     (rst_n),
        .rx_in     (rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          edge_n;
        logic [DW-1:0] data;
        logic        perr;
        logic        ferr;
    } exp_t;

    typedef struct {
        int lo;
        int hi;
    } span_t;

    exp_t  exp_q[$];
    span_t busy_q[$];

    logic [DW-1:0] m_data = '0;
    logic          m_perr = 1'b0;
    logic          m_ferr = 1'b0;
    logic          cmp_v;
    logic          cmp_b;

    int            obs_cyc[$];
    logic [DW-1:0] obs_data[$];
    logic          obs_perr[$];
    logic          obs_ferr[$];
    int            busy_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Compare process: outputs are checked mid-cycle, away from the edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            busy_q.delete();
            m_data = '0;
            m_perr = 1'b0;
            m_ferr = 1'b0;
        end
        while (busy_q.size() > 0 && busy_q[0].hi < cyc) busy_q.delete(0);
        cmp_b = (busy_q.size() > 0 && busy_q[0].lo <= cyc);
        cmp_v = (exp_q.size() > 0 && exp_q[0].edge_n == cyc);
        if (cmp_v) begin
            m_data = exp_q[0].data;
            m_perr = exp_q[0].perr;
            m_ferr = exp_q[0].ferr;
            exp_q.delete(0);
        end
        check("rx_valid",   32'(rx_valid),   32'(cmp_v));
        check("rx_busy",    32'(rx_busy),    32'(cmp_b));
        check("rx_data",    32'(rx_data),    32'(m_data));
        check("parity_err", 32'(parity_err), 32'(m_perr));
        check("frame_err",  32'(frame_err),  32'(m_ferr));
        if (rx_valid === 1'b1) begin
            obs_cyc.push_back(cyc);
            obs_data.push_back(rx_data);
            obs_perr.push_back(parity_err);
            obs_ferr.push_back(frame_err);
        end
        if (rx_busy === 1'b1) busy_cnt++;
    end

    // Caller is always positioned just after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) step();
    endtask

    task automatic drive_bits(input logic [10:0] bits, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            rx_in = bits[c / OS];
            step();
        end
    endtask

    // Word must appear the cycle after edge k+3+OS/2+(DW+2)*OS, where k is
    // the edge that first captures the start bit; busy spans k+2 up to that.
    task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stp,
                              output int k);
        exp_t  e;
        span_t s;
        k        = cyc + 1;
        e.edge_n = k + 3 + OS / 2 + (DW + 2) * OS;
        e.data   = d;
        e.perr   = (par != ~^d);
        e.ferr   = ~stp;
        s.lo     = k + 2;
        s.hi     = e.edge_n - 1;
        exp_q.push_back(e);
        busy_q.push_back(s);
        drive_bits({stp, par, d, 1'b0}, FRAME);
    endtask

    int    k0;
    int    k1;
    int    n0;
    int    b0;
    span_t sp;

    initial begin
        // Reset state
        repeat (3) step();
        check("reset rx_data",    32'(rx_data),    32'h0);
        check("reset rx_valid",   32'(rx_valid),   32'h0);
        check("reset parity_err", 32'(parity_err), 32'h0);
        check("reset frame_err",  32'(frame_err),  32'h0);
        check("reset rx_busy",    32'(rx_busy),    32'h0);
        rst_n = 1'b1;
        idle(5);

        // Single byte 0xA5, correct odd parity
        n0 = obs_cyc.size();
        send_frame(8'hA5, 1'b1, 1'b1, k0);
        check("a5 count", 32'(obs_cyc.size() - n0), 32'd1);
        if (obs_cyc.size() > n0) begin
            check("a5 latency", 32'(obs_cyc[n0] - k0), 32'd171);
            check("a5 data",    32'(obs_data[n0]),     32'hA5);
            check("a5 perr",    32'(obs_perr[n0]),     32'h0);
            check("a5 ferr",    32'(obs_ferr[n0]),     32'h0);
        end
        idle(10);

        // Parity error on 0x3C
        n0 = obs_cyc.size();
        send_frame(8'h3C, 1'b0, 1'b1, k0);
        check("3c count", 32'(obs_cyc.size() - n0), 32'd1);
        if (obs_cyc.size() > n0) begin
            check("3c data", 32'(obs_data[n0]), 32'h3C);
            check("3c perr", 32'(obs_perr[n0]), 32'h1);
            check("3c ferr", 32'(obs_ferr[n0]), 32'h0);
        end
        idle(10);

        // Frame error, then line held low for 40 bit times
        n0 = obs_cyc.size();
        send_frame(8'h00, 1'b1, 1'b0, k0);
        rx_in = 1'b0;
        repeat (40 * OS) step();
        idle(20);
        check("ferr count", 32'(obs_cyc.size() - n0), 32'd1);
        if (obs_cyc.size() > n0) begin
            check("ferr data", 32'(obs_data[n0]), 32'h00);
            check("ferr perr", 32'(obs_perr[n0]), 32'h0);
            check("ferr flag", 32'(obs_ferr[n0]), 32'h1);
        end
        idle(10);

        // False start: 4 low cycles
        n0    = obs_cyc.size();
        b0    = busy_cnt;
        k0    = cyc + 1;
        sp.lo = k0 + 2;
        sp.hi = k0 + 1 + OS / 2;
        busy_q.push_back(sp);
        rx_in = 1'b0;
        repeat (4) step();
        idle(2 * OS);
        check("false start valid", 32'(obs_cyc.size() - n0), 32'd0);
        check("false start busy cycles", 32'(busy_cnt - b0), 32'd8);

        // Back-to-back frames
        n0 = obs_cyc.size();
        send_frame(8'h01, 1'b0, 1'b1, k0);
        send_frame(8'hFF, 1'b1, 1'b1, k1);
        send_frame(8'h80, 1'b0, 1'b1, k1);
        idle(10);
        check("b2b count", 32'(obs_cyc.size() - n0), 32'd3);
        if (obs_cyc.size() >= n0 + 3) begin
            check("b2b first latency", 32'(obs_cyc[n0] - k0),              32'd171);
            check("b2b gap 1",         32'(obs_cyc[n0+1] - obs_cyc[n0]),   32'd176);
            check("b2b gap 2",         32'(obs_cyc[n0+2] - obs_cyc[n0+1]), 32'd176);
            check("b2b data 0",        32'(obs_data[n0]),                  32'h01);
            check("b2b data 1",        32'(obs_data[n0+1]),                32'hFF);
            check("b2b data 2",        32'(obs_data[n0+2]),                32'h80);
            check("b2b errs",          32'({obs_perr[n0], obs_perr[n0+1], obs_perr[n0+2],
                                            obs_ferr[n0], obs_ferr[n0+1], obs_ferr[n0+2]}),
                                       32'h0);
        end

        // Reset during data bit 4 of 0x55, then 0x12
        n0    = obs_cyc.size();
        k0    = cyc + 1;
        sp.lo = k0 + 2;
        sp.hi = k0 + 100000;
        busy_q.push_back(sp);
        drive_bits({1'b1, 1'b1, 8'h55, 1'b0}, 5 * OS + 8);
        rst_n = 1'b0;
        rx_in = 1'b1;
        #1;
        check("midreset rx_data", 32'(rx_data), 32'h0);
        check("midreset rx_busy", 32'(rx_busy), 32'h0);
        repeat (3) step();
        check("midreset valid", 32'(rx_valid), 32'h0);
        rst_n = 1'b1;
        idle(2 * OS);
        check("midreset no word", 32'(obs_cyc.size() - n0), 32'd0);
        send_frame(8'h12, 1'b1, 1'b1, k0);
        idle(10);
        check("12 count", 32'(obs_cyc.size() - n0), 32'd1);
        if (obs_cyc.size() > n0) begin
            check("12 latency", 32'(obs_cyc[n0] - k0), 32'd171);
            check("12 data",    32'(obs_data[n0]),     32'h12);
            check("12 perr",    32'(obs_perr[n0]),     32'h0);
            check("12 ferr",    32'(obs_ferr[n0]),     32'h0);
        end

        idle(20);
        check("pending words", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
